// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register bank's single write port among
// three writeback sources, plus a busy scoreboard that drives decode's RAW/WAW stalls.
module regfile_write_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 raw_stall,
  output logic                 waw_stall,
  output logic [31:0]          busy_vec
);

  logic [1:0]      last;
  logic [1:0]      cand;
  logic [1:0]      gnt_idx_p0;
  logic            vld_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] data_p0;

  logic            vld_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;

  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic            set_en;

  // Requester index after i, wrapping modulo 3.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // ---- p0: arbitration and write-data selection ----
  always_comb begin
    gnt_idx_p0 = last;
    vld_p0     = 1'b0;
    cand       = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_next(cand);
      if (!vld_p0 && req_valid[cand]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = cand;
      end
    end
    if (rst) vld_p0 = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (vld_p0) req_ready[gnt_idx_p0] = 1'b1;
  end

  always_comb begin
    rd_p0   = req_rd[4:0];
    data_p0 = req_data[XLEN-1:0];
    case (gnt_idx_p0)
      2'd1: begin
        rd_p0   = req_rd[9:5];
        data_p0 = req_data[2*XLEN-1:XLEN];
      end
      2'd2: begin
        rd_p0   = req_rd[14:10];
        data_p0 = req_data[3*XLEN-1:2*XLEN];
      end
      default: ;
    endcase
  end

  // ---- p1: registered write port; x0 writes are accepted but never enabled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 2'd2;
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && (rd_p0 != 5'd0);
      if (vld_p0) begin
        last    <= gnt_idx_p0;
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wb_we   = vld_p1;
  assign wb_rd   = rd_p1;
  assign wb_data = data_p1;

  // ---- scoreboard: clear on bank commit, set on issue; set wins on collision ----
  assign waw_stall = !rst && issue_valid && busy[issue_rd];
  assign raw_stall = !rst && (busy[rs1_addr] || busy[rs2_addr]);
  assign set_en    = issue_valid && !waw_stall && (issue_rd != 5'd0);

  always_comb begin
    busy_nxt = busy;
    if (vld_p1) busy_nxt[rd_p1] = 1'b0;
    if (set_en) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of grants, write port and scoreboard.
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [14:0]  req_rd;
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic         wb_we;
  logic [4:0]   wb_rd;
  logic [63:0]  wb_data;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic         raw_stall;
  logic         waw_stall;
  logic [31:0]  busy_vec;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          m_last = 2;
  logic [31:0] m_busy = '0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;
  int          m_gnt_prev = -1;

  regfile_write_arbiter #(.XLEN(64), .NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .raw_stall(raw_stall), .waw_stall(waw_stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Highest-priority valid requester: scan last+1, last+2, last (mod 3).
  function automatic int mdl_grant();
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (m_last + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one edge using the current inputs, then cross the edge.
  task automatic step();
    int g;
    logic [31:0] nb;
    g = rst ? -1 : mdl_grant();
    m_gnt_prev = g;
    if (rst) begin
      m_last = 2; m_busy = '0; m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_rd] = 1'b0;
      if (issue_valid && !m_busy[issue_rd] && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (g >= 0) begin
        m_last = g;
        m_rd   = req_rd[5*g +: 5];
        m_data = req_data[64*g +: 64];
        m_we   = (m_rd != 5'd0);
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
    step(); step();
    @(negedge clk);
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp %b", req_ready, 3'b000); end
    checks++; if (raw_stall !== 1'b0 || waw_stall !== 1'b0) begin errors++; $display("FAIL rst_stalls got raw=%b waw=%b exp 0 0", raw_stall, waw_stall); end
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'd0) begin errors++; $display("FAIL rst_wb got we=%b rd=%0d data=%h exp 0 0 0", wb_we, wb_rd, wb_data); end
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy_vec); end
    step();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_write();
    req_valid = 3'b001; req_rd[4:0] = 5'd7; req_data[63:0] = 64'h5;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp %b", req_ready, 3'b001); end
    step();
    req_valid = 3'b000;
    @(negedge clk);
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h5) begin errors++; $display("FAIL single_wb got we=%b rd=%0d data=%h exp 1 7 5", wb_we, wb_rd, wb_data); end
    step();
    @(negedge clk);
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b exp 0", wb_we); end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
    req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {64'h33, 64'h22, 64'h11};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = 3'(1 << (k % 3));
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp); end
      if (k > 0) begin
        checks++; if (wb_rd !== 5'((k - 1) % 3 + 1)) begin errors++; $display("FAIL rr_wbrd%0d got %0d exp %0d", k, wb_rd, (k - 1) % 3 + 1); end
      end
      step();
    end
    @(negedge clk);
    checks++; if (wb_rd !== 5'd1 || wb_data !== 64'h11) begin errors++; $display("FAIL rr_wrap got rd=%0d data=%h exp 1 11", wb_rd, wb_data); end
    idle();
    step();
  endtask

  task automatic test_x0_write();
    req_valid = 3'b010; req_rd[9:5] = 5'd0; req_data[127:64] = 64'hFF;
    @(negedge clk);
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL x0_ready got %b exp %b", req_ready, 3'b010); end
    step();
    idle();
    @(negedge clk);
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", wb_we); end
    checks++; if (wb_data !== 64'hFF) begin errors++; $display("FAIL x0_data got %h exp ff", wb_data); end
    checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL x0_busy got %h exp %h", busy_vec, m_busy); end
    step();
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd5;
    @(negedge clk);
    checks++; if (waw_stall !== 1'b0) begin errors++; $display("FAIL raw_issue_waw got %b exp 0", waw_stall); end
    step();
    issue_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    @(negedge clk);
    checks++; if (raw_stall !== 1'b0 || busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_x0src got raw=%b busy5=%b exp 0 1", raw_stall, busy_vec[5]); end
    step();
    rs1_addr = 5'd5;
    @(negedge clk);
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL raw_busy got %b exp 1", raw_stall); end
    step();
    req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[63:0] = 64'hABC;
    @(negedge clk);
    checks++; if (raw_stall !== 1'b1 || req_ready !== 3'b001) begin errors++; $display("FAIL raw_hs got raw=%b ready=%b exp 1 001", raw_stall, req_ready); end
    step();
    req_valid = 3'b000;
    @(negedge clk);
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || raw_stall !== 1'b1) begin errors++; $display("FAIL raw_commit got we=%b rd=%0d raw=%b exp 1 5 1", wb_we, wb_rd, raw_stall); end
    step();
    @(negedge clk);
    checks++; if (raw_stall !== 1'b0 || busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_release got raw=%b busy5=%b exp 0 0", raw_stall, busy_vec[5]); end
    step();
    idle();
  endtask

  task automatic test_waw_setclear();
    req_valid = 3'b001; req_rd[4:0] = 5'd9; req_data[63:0] = 64'h9;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL waw_ready1 got %b exp 001", req_ready); end
    step();
    req_valid = 3'b000; issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd9 || waw_stall !== 1'b0 || busy_vec[9] !== 1'b0) begin errors++; $display("FAIL waw_collide got we=%b rd=%0d waw=%b busy9=%b exp 1 9 0 0", wb_we, wb_rd, waw_stall, busy_vec[9]); end
    step();
    req_valid = 3'b001;
    @(negedge clk);
    checks++; if (busy_vec[9] !== 1'b1 || waw_stall !== 1'b1) begin errors++; $display("FAIL waw_setwins got busy9=%b waw=%b exp 1 1", busy_vec[9], waw_stall); end
    step();
    req_valid = 3'b000;
    @(negedge clk);
    checks++; if (wb_we !== 1'b1 || waw_stall !== 1'b1) begin errors++; $display("FAIL waw_stalled got we=%b waw=%b exp 1 1", wb_we, waw_stall); end
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL waw_noset got busy9=%b exp 0", busy_vec[9]); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    issue_rd = 5'd6;
    step();
    issue_valid = 1'b0;
    req_valid = 3'b001; req_rd[4:0] = 5'd3; req_data[63:0] = 64'h77;
    @(negedge clk);
    checks++; if (busy_vec !== 32'h50 || req_ready !== 3'b001) begin errors++; $display("FAIL mid_pre got busy=%h ready=%b exp 50 001", busy_vec, req_ready); end
    step();
    rst = 1'b1; req_valid = 3'b011; req_rd[9:5] = 5'd8;
    @(negedge clk);
    checks++; if (wb_we !== 1'b1 || req_ready !== 3'b000) begin errors++; $display("FAIL mid_inrst got we=%b ready=%b exp 1 000", wb_we, req_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wb_we !== 1'b0 || busy_vec !== 32'd0) begin errors++; $display("FAIL mid_post got we=%b busy=%h exp 0 0", wb_we, busy_vec); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_first_grant got %b exp 001", req_ready); end
    step();
    idle();
    step();
  endtask

  task automatic test_random();
    int g;
    logic [2:0] e_ready;
    logic e_raw, e_waw;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || m_gnt_prev == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_rd[5*i +: 5] = 5'($urandom_range(0, 7));
          req_data[64*i +: 64] = {$urandom, $urandom};
        end
      end
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      g = rst ? -1 : mdl_grant();
      e_ready = (g < 0) ? 3'b000 : 3'(1 << g);
      e_raw = !rst && (m_busy[rs1_addr] || m_busy[rs2_addr]);
      e_waw = !rst && issue_valid && m_busy[issue_rd];
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, req_ready, e_ready); end
      checks++; if (raw_stall !== e_raw || waw_stall !== e_waw) begin errors++; $display("FAIL rnd_stall n=%0d got raw=%b waw=%b exp %b %b", n, raw_stall, waw_stall, e_raw, e_waw); end
      checks++; if (wb_we !== m_we || wb_rd !== m_rd || wb_data !== m_data) begin errors++; $display("FAIL rnd_wb n=%0d got we=%b rd=%0d data=%h exp %b %0d %h", n, wb_we, wb_rd, wb_data, m_we, m_rd, m_data); end
      checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %h exp %h", n, busy_vec, m_busy); end
      step();
    end
    rst = 1'b0;
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0_write();
    test_raw();
    test_waw_setclear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
